// File: rtl/state_compress_poly_compress_if.sv
// Request/result bundle for the poly-compress stage: start + input vector in,
// completion pulse + packed compressed vector out.
interface state_compress_poly_compress_if #(
    parameter int KYBER_N        = 256,
    parameter int i_Coeffs_Width = 12,
    parameter int D              = 10
);
    localparam int i_Poly_Size = i_Coeffs_Width * KYBER_N;
    localparam int o_Poly_Size = D * KYBER_N;

    logic                   enable;
    logic [i_Poly_Size-1:0] iPoly;
    logic                   Poly_Compress_done;
    logic [o_Poly_Size-1:0] oPoly;

    modport master (
        output enable,
        output iPoly,
        input  Poly_Compress_done,
        input  oPoly
    );

    modport slave (
        input  enable,
        input  iPoly,
        output Poly_Compress_done,
        output oPoly
    );
endinterface

// File: rtl/state_compress_poly_compress.sv
// Sequential Kyber coefficient compression: c = round(x * 2^D / Q) mod 2^D,
// one coefficient per cycle, whole polynomial published with a one-cycle done pulse.
module state_compress_poly_compress #(
    parameter int KYBER_N        = 256,
    parameter int KYBER_Q        = 3329,
    parameter int i_Coeffs_Width = 12,
    parameter int D              = 10
) (
    input  logic                            clk,
    input  logic                            reset,
    state_compress_poly_compress_if.slave   bus
);
    localparam int i_Poly_Size = i_Coeffs_Width * KYBER_N;
    localparam int o_Poly_Size = D * KYBER_N;
    localparam int IDX_W       = $clog2(KYBER_N);

    // t = x*2^D + (Q-1)/2 is below 2^24 for 12-bit x and D <= 11.
    localparam int T_W         = 24;
    localparam int RECIP_SHIFT = 32;
    localparam int RECIP_W     = 22;
    localparam int PROD_W      = T_W + RECIP_W;
    localparam int Q_W         = PROD_W - RECIP_SHIFT;

    localparam longint unsigned RECIP_L = (64'd1 << RECIP_SHIFT) / KYBER_Q;
    localparam logic [RECIP_W-1:0] RECIP  = RECIP_W'(RECIP_L);
    localparam logic [T_W-1:0]     Q_T    = T_W'(KYBER_Q);
    localparam logic [T_W-1:0]     HALF_Q = T_W'((KYBER_Q - 1) / 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPRESS,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [IDX_W-1:0]       r_idx;
    logic [i_Poly_Size-1:0] r_in;
    logic [o_Poly_Size-1:0] r_work;
    logic [o_Poly_Size-1:0] r_out;
    logic                   r_done;

    logic [i_Coeffs_Width-1:0] w_x;
    logic [T_W-1:0]            w_t;
    logic [PROD_W-1:0]         w_prod;
    logic [Q_W-1:0]            w_q_est;
    logic [T_W-1:0]            w_qq;
    logic [T_W-1:0]            w_rem;
    logic [Q_W-1:0]            w_q;
    logic [D-1:0]              w_c;
    logic                      w_last;

    // Reciprocal estimate undershoots floor(t/Q) by at most one since t < 2^32,
    // so a single remainder compare restores the exact quotient.
    always_comb begin
        w_x     = r_in[r_idx*i_Coeffs_Width +: i_Coeffs_Width];
        w_t     = (T_W'(w_x) << D) + HALF_Q;
        w_prod  = PROD_W'(w_t) * PROD_W'(RECIP);
        w_q_est = Q_W'(w_prod >> RECIP_SHIFT);
        w_qq    = T_W'(w_q_est) * Q_T;
        w_rem   = w_t - w_qq;
        w_q     = (w_rem >= Q_T) ? (w_q_est + 1'b1) : w_q_est;
        w_c     = D'(w_q);
        w_last  = (r_idx == IDX_W'(KYBER_N - 1));
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (bus.enable) w_next_state = S_COMPRESS;
            S_COMPRESS: if (w_last)     w_next_state = S_DONE;
            S_DONE:                     w_next_state = S_IDLE;
            default:                    w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx  <= '0;
            r_in   <= '0;
            r_work <= '0;
            r_out  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.enable) begin
                        r_in  <= bus.iPoly;
                        r_idx <= '0;
                    end
                end
                S_COMPRESS: begin
                    r_work[r_idx*D +: D] <= w_c;
                    r_idx                <= r_idx + 1'b1;
                end
                S_DONE: begin
                    r_out  <= r_work;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.oPoly              = r_out;
    assign bus.Poly_Compress_done = r_done;
endmodule
